// File: rtl/turn_sequencer.sv
// Per-turn aim/charge/launch/flight/settle sequencer; owns both players' HP.
// Optional build macro TURN_TIMEOUT_EN adds an AIM+CHARGE tick budget.
//
// state   | meaning
// IDLE    | waiting for exactly one turn flag
// AIM     | owner aiming, waiting for fire press
// CHARGE  | fire held, power ramps on each tick
// FLIGHT  | projectile in the air, waiting for proj_done
// SETTLE  | counting SETTLE_TICKS ticks after impact
// DONE    | one-cycle turn_done pulse to game_fsm
// RELEASE | waiting for game_fsm to drop the owner's flag
module turn_sequencer #(
  parameter int HP_MAX        = 100,
  parameter int DAMAGE        = 20,
  parameter int POWER_MAX     = 100,
  parameter int POWER_STEP    = 2,
  parameter int SETTLE_TICKS  = 30,
  parameter int TIMEOUT_TICKS = 900
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dog_turn,
  input  logic       cat_turn,
  input  logic       start_game,
  input  logic       fire_press,
  input  logic       tick,
  input  logic       proj_done,
  input  logic       proj_hit,
  output logic       launch,
  output logic       shooter,
  output logic [6:0] power,
  output logic [9:0] hp_dog,
  output logic [9:0] hp_cat,
  output logic       turn_done_dog,
  output logic       turn_done_cat,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AIM     = 3'd1,
    S_CHARGE  = 3'd2,
    S_FLIGHT  = 3'd3,
    S_SETTLE  = 3'd4,
    S_DONE    = 3'd5,
    S_RELEASE = 3'd6
  } state_t;

  localparam int SW = $clog2(SETTLE_TICKS + 1);

  state_t        state;
  logic          fire_q;
  logic          start_q;
  logic [SW-1:0] settle_cnt;

  logic       owner_flag;
  logic       fire_rise;
  logic       fire_fall;
  logic       start_rise;
  logic       timeout_now;
  logic [7:0] power_sum;
  logic [6:0] power_sat;
  logic [9:0] hp_dog_dmg;
  logic [9:0] hp_cat_dmg;

  assign owner_flag = shooter ? cat_turn : dog_turn;
  assign fire_rise  = fire_press & ~fire_q;
  assign fire_fall  = ~fire_press & fire_q;
  assign start_rise = start_game & ~start_q;

  assign power_sum  = {1'b0, power} + 8'(POWER_STEP);
  assign power_sat  = (power_sum > 8'(POWER_MAX)) ? 7'(POWER_MAX) : power_sum[6:0];

  // Saturate at zero rather than wrapping when HP is below one hit.
  assign hp_dog_dmg = (hp_dog > 10'(DAMAGE)) ? hp_dog - 10'(DAMAGE) : 10'd0;
  assign hp_cat_dmg = (hp_cat > 10'(DAMAGE)) ? hp_cat - 10'(DAMAGE) : 10'd0;

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] to_cnt;

  // Budget reloads while idle and spans AIM and CHARGE without restarting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= TW'(TIMEOUT_TICKS);
    end else if (state == S_IDLE) begin
      to_cnt <= TW'(TIMEOUT_TICKS);
    end else if ((state == S_AIM || state == S_CHARGE) && tick && to_cnt != '0) begin
      to_cnt <= to_cnt - TW'(1);
    end
  end

  assign timeout_now = tick && (to_cnt == TW'(1)) &&
                       (state == S_AIM || state == S_CHARGE);
`else
  assign timeout_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      shooter       <= 1'b0;
      power         <= 7'd0;
      launch        <= 1'b0;
      turn_done_dog <= 1'b0;
      turn_done_cat <= 1'b0;
      hp_dog        <= 10'(HP_MAX);
      hp_cat        <= 10'(HP_MAX);
      fire_q        <= 1'b0;
      start_q       <= 1'b0;
      settle_cnt    <= '0;
    end else begin
      fire_q        <= fire_press;
      start_q       <= start_game;
      launch        <= 1'b0;
      turn_done_dog <= 1'b0;
      turn_done_cat <= 1'b0;

      case (state)
        S_IDLE: begin
          if (dog_turn ^ cat_turn) begin
            state   <= S_AIM;
            shooter <= cat_turn;
            power   <= 7'd0;
          end
        end
        S_AIM: begin
          if (!owner_flag) begin
            state <= S_IDLE;
          end else if (timeout_now) begin
            state      <= S_SETTLE;
            settle_cnt <= SW'(SETTLE_TICKS);
          end else if (fire_rise) begin
            state <= S_CHARGE;
          end
        end
        S_CHARGE: begin
          if (!owner_flag) begin
            state <= S_IDLE;
          end else begin
            if (tick) power <= power_sat;
            if (fire_fall || timeout_now) begin
              launch <= 1'b1;
              state  <= S_FLIGHT;
            end
          end
        end
        S_FLIGHT: begin
          if (!owner_flag) begin
            state <= S_IDLE;
          end else if (proj_done) begin
            state      <= S_SETTLE;
            settle_cnt <= SW'(SETTLE_TICKS);
            if (proj_hit) begin
              if (shooter) hp_dog <= hp_dog_dmg;
              else         hp_cat <= hp_cat_dmg;
            end
          end
        end
        S_SETTLE: begin
          if (!owner_flag) begin
            state <= S_IDLE;
          end else if (tick) begin
            if (settle_cnt == SW'(1)) begin
              state         <= S_DONE;
              turn_done_dog <= ~shooter;
              turn_done_cat <= shooter;
            end else begin
              settle_cnt <= settle_cnt - SW'(1);
            end
          end
        end
        S_DONE: state <= S_RELEASE;
        S_RELEASE: begin
          if (!owner_flag) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Reload overrides any hit landing in the same cycle.
      if (start_rise) begin
        hp_dog <= 10'(HP_MAX);
        hp_cat <= 10'(HP_MAX);
      end
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_turn_sequencer.sv
// Self-checking bench for turn_sequencer: vector table plus hand-written
// corner sequences; launch power and done pulses go through a scoreboard.
module tb_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dog_turn, cat_turn, start_game, fire_press, tick, proj_done, proj_hit;
  logic       launch, shooter, turn_done_dog, turn_done_cat;
  logic [6:0] power;
  logic [9:0] hp_dog, hp_cat;
  logic [2:0] seq_state;

  int n_chk  = 0;
  int n_fail = 0;
  int n_launch = 0, n_launch_exp = 0;
  int n_done = 0, n_done_exp = 0;
  int m_hp_dog = 100, m_hp_cat = 100;

  int       lq[$];
  bit [1:0] dq[$];

  turn_sequencer #(.TIMEOUT_TICKS(5)) dut (
    .clk(clk), .rst_n(rst_n), .dog_turn(dog_turn), .cat_turn(cat_turn),
    .start_game(start_game), .fire_press(fire_press), .tick(tick),
    .proj_done(proj_done), .proj_hit(proj_hit), .launch(launch),
    .shooter(shooter), .power(power), .hp_dog(hp_dog), .hp_cat(hp_cat),
    .turn_done_dog(turn_done_dog), .turn_done_cat(turn_done_cat),
    .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
    end
  endtask

  task automatic push_launch(input int pw);
    lq.push_back(pw);
    n_launch_exp++;
  endtask

  task automatic push_done(input bit [1:0] code);
    dq.push_back(code);
    n_done_exp++;
  endtask

  function automatic int dmg(input int hp);
    return (hp > 20) ? hp - 20 : 0;
  endfunction

  // Scoreboard monitor for pulse outputs.
  always @(posedge clk) begin
    #1;
    if (rst_n && launch) begin
      n_launch++;
      if (lq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_launch: got launch=1 expected launch=0 (power %0d)", power);
      end else begin
        chk("launch_power", int'(power), lq.pop_front());
      end
    end
    if (rst_n && (turn_done_dog || turn_done_cat)) begin
      n_done++;
      if (dq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done: got dog=%0d cat=%0d expected none", turn_done_dog, turn_done_cat);
      end else begin
        chk("done_pulse", int'({turn_done_dog, turn_done_cat}), int'(dq.pop_front()));
      end
    end
  end

  typedef struct {
    bit dog, cat, start, fire, pd, ph;
    int nt;
    bit el;
    bit [1:0] ed;
    int st, pw, sh, hd, hc;
  } vec_t;

  task automatic apply(input vec_t v, input int idx);
    dog_turn = v.dog; cat_turn = v.cat; start_game = v.start;
    fire_press = v.fire; proj_done = v.pd; proj_hit = v.ph; tick = 1'b0;
    if (v.el) push_launch(v.pw);
    if (v.ed != 2'b00) push_done(v.ed);
    cyc();
    proj_done = 1'b0; proj_hit = 1'b0;
    tick_n(v.nt);
    chk($sformatf("vec%0d_state", idx), int'(seq_state), v.st);
    chk($sformatf("vec%0d_power", idx), int'(power), v.pw);
    chk($sformatf("vec%0d_shooter", idx), int'(shooter), v.sh);
    chk($sformatf("vec%0d_hp_dog", idx), int'(hp_dog), v.hd);
    chk($sformatf("vec%0d_hp_cat", idx), int'(hp_cat), v.hc);
  endtask

  // Complete turn: press, charge nt ticks, release, land, settle, hand back.
  task automatic full_turn(input bit who, input int nt, input bit hit);
    int pw;
    dog_turn = ~who; cat_turn = who; cyc();
    chk("turn_aim_state", int'(seq_state), 1);
    chk("turn_shooter", int'(shooter), int'(who));
    fire_press = 1'b1; cyc();
    chk("turn_charge_state", int'(seq_state), 2);
    tick_n(nt);
    pw = (2 * nt > 100) ? 100 : 2 * nt;
    fire_press = 1'b0; push_launch(pw); cyc();
    chk("turn_flight_state", int'(seq_state), 3);
    proj_done = 1'b1; proj_hit = hit; cyc();
    proj_done = 1'b0; proj_hit = 1'b0;
    if (hit) begin
      if (who) m_hp_dog = dmg(m_hp_dog);
      else     m_hp_cat = dmg(m_hp_cat);
    end
    chk("turn_hp_dog", int'(hp_dog), m_hp_dog);
    chk("turn_hp_cat", int'(hp_cat), m_hp_cat);
    push_done(who ? 2'b01 : 2'b10);
    tick_n(30);
    chk("turn_release_state", int'(seq_state), 6);
    dog_turn = 1'b0; cat_turn = 1'b0; cyc();
    chk("turn_idle_state", int'(seq_state), 0);
  endtask

  vec_t v[16];

  initial begin
    v[0]  = '{0,0,1,0,0,0,  0,0,2'b00, 0,  0,0,100,100};
    v[1]  = '{1,0,1,0,0,0,  0,0,2'b00, 1,  0,0,100,100};
    v[2]  = '{1,0,1,1,0,0,  0,0,2'b00, 2,  0,0,100,100};
    v[3]  = '{1,0,1,1,0,0, 10,0,2'b00, 2, 20,0,100,100};
    v[4]  = '{1,0,1,0,0,0,  0,1,2'b00, 3, 20,0,100,100};
    v[5]  = '{1,0,1,0,1,1,  0,0,2'b00, 4, 20,0,100, 80};
    v[6]  = '{1,0,1,0,0,0, 29,0,2'b00, 4, 20,0,100, 80};
    v[7]  = '{1,0,1,0,0,0,  1,0,2'b10, 6, 20,0,100, 80};
    v[8]  = '{0,0,1,0,0,0,  0,0,2'b00, 0, 20,0,100, 80};
    v[9]  = '{0,1,1,0,0,0,  0,0,2'b00, 1,  0,1,100, 80};
    v[10] = '{0,1,1,1,0,0,  0,0,2'b00, 2,  0,1,100, 80};
    v[11] = '{0,1,1,1,0,0, 80,0,2'b00, 2,100,1,100, 80};
    v[12] = '{0,1,1,0,0,0,  0,1,2'b00, 3,100,1,100, 80};
    v[13] = '{0,1,1,0,1,1,  0,0,2'b00, 4,100,1, 80, 80};
    v[14] = '{0,1,1,0,0,0, 30,0,2'b01, 6,100,1, 80, 80};
    v[15] = '{0,0,1,0,0,0,  0,0,2'b00, 0,100,1, 80, 80};

    rst_n = 1'b0;
    dog_turn = 0; cat_turn = 0; start_game = 0; fire_press = 0;
    tick = 0; proj_done = 0; proj_hit = 0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_state", int'(seq_state), 0);
    chk("rst_power", int'(power), 0);
    chk("rst_shooter", int'(shooter), 0);
    chk("rst_hp_dog", int'(hp_dog), 100);
    chk("rst_hp_cat", int'(hp_cat), 100);
    chk("rst_pulses", int'({launch, turn_done_dog, turn_done_cat}), 0);

`ifndef TURN_TIMEOUT_EN
    for (int i = 0; i < 16; i++) apply(v[i], i);
    m_hp_dog = 80; m_hp_cat = 80;
    start_game = 1'b0; cyc();

    // Cat hits dog down to zero, then once more at zero: no wrap.
    for (int i = 0; i < 5; i++) full_turn(1'b1, 3 + i, 1'b1);
    chk("hp_dog_floor", int'(hp_dog), 0);

    // Cat misses: HP unchanged, single done pulse.
    full_turn(1'b1, 5, 1'b0);
`endif

    // Abort mid-CHARGE, then stray fire edge and proj_done in IDLE.
    dog_turn = 1'b1; cyc();
    fire_press = 1'b1; cyc();
    tick_n(3);
    dog_turn = 1'b0; cyc();
    chk("abort_state", int'(seq_state), 0);
    fire_press = 1'b0; cyc();
    proj_done = 1'b1; proj_hit = 1'b1; cyc();
    proj_done = 1'b0; proj_hit = 1'b0; cyc();
    chk("abort_state_after_done", int'(seq_state), 0);
    chk("abort_hp_dog", int'(hp_dog), m_hp_dog);
    chk("abort_hp_cat", int'(hp_cat), m_hp_cat);

    // Both flags high is illegal.
    dog_turn = 1'b1; cat_turn = 1'b1; cyc();
    chk("illegal_both_state", int'(seq_state), 0);
    cyc();
    chk("illegal_both_state2", int'(seq_state), 0);
    dog_turn = 1'b0; cat_turn = 1'b0; cyc();

`ifndef TURN_TIMEOUT_EN
    // Tick coinciding with release is counted into the launch power.
    dog_turn = 1'b1; cyc();
    fire_press = 1'b1; cyc();
    tick_n(4);
    chk("coinc_power_pre", int'(power), 8);
    fire_press = 1'b0; tick = 1'b1; push_launch(10); cyc();
    tick = 1'b0;
    chk("coinc_state", int'(seq_state), 3);
    chk("coinc_power", int'(power), 10);

    // start_game rising edge together with a hit: reload wins.
    start_game = 1'b1; proj_done = 1'b1; proj_hit = 1'b1; cyc();
    proj_done = 1'b0; proj_hit = 1'b0;
    m_hp_dog = 100; m_hp_cat = 100;
    chk("reload_state", int'(seq_state), 4);
    chk("reload_hp_dog", int'(hp_dog), m_hp_dog);
    chk("reload_hp_cat", int'(hp_cat), m_hp_cat);
    dog_turn = 1'b0; cyc();
    chk("settle_abort_state", int'(seq_state), 0);

    // Without the timeout, AIM waits indefinitely.
    dog_turn = 1'b1; cyc();
    tick_n(20);
    chk("aim_wait_state", int'(seq_state), 1);
    dog_turn = 1'b0; cyc();
    chk("aim_wait_abort", int'(seq_state), 0);
`else
    // Timeout in AIM forfeits the shot.
    dog_turn = 1'b1; cyc();
    tick_n(4);
    chk("to_aim_pre_state", int'(seq_state), 1);
    tick_n(1);
    chk("to_aim_state", int'(seq_state), 4);
    chk("to_aim_power", int'(power), 0);
    dog_turn = 1'b0; cyc();
    chk("to_aim_abort", int'(seq_state), 0);

    // Timeout in CHARGE forces a launch with the current power.
    dog_turn = 1'b1; cyc();
    fire_press = 1'b1; cyc();
    chk("to_charge_state", int'(seq_state), 2);
    tick_n(4);
    chk("to_charge_pre_state", int'(seq_state), 2);
    push_launch(10);
    tick_n(1);
    chk("to_charge_flight", int'(seq_state), 3);
    chk("to_charge_power", int'(power), 10);
    dog_turn = 1'b0; fire_press = 1'b0; cyc();
    chk("to_charge_abort", int'(seq_state), 0);
`endif

    repeat (3) cyc();
    chk("launch_count", n_launch, n_launch_exp);
    chk("done_count", n_done, n_done_exp);
    chk("launch_queue_left", lq.size(), 0);
    chk("done_queue_left", dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
